prn_search_ctrl: RTL

PRN_SEARCH_CTRL -- requirements
Module: prn_search_ctrl

---
 rtl/prn_pkg.sv | 23 ++
 rtl/prn_search_ctrl_if.sv | 37 +++
 rtl/prn_fcw_calc.sv | 22 ++
 rtl/prn_search_ctrl.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/prn_pkg.sv
// Shared types and constants for the PRN acquisition/tracking search controller.
package prn_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ACQ_LOAD = 3'd1,
        ST_ACQ_RUN  = 3'd2,
        ST_BIN_STEP = 3'd3,
        ST_TRK_LOAD = 3'd4,
        ST_TRK      = 3'd5
    } prn_state_e;

    localparam logic [2:0] PARAL_ACQ  = 3'b100;
    localparam logic [2:0] PARAL_TRK  = 3'b000;
    localparam int         CODE_CHIPS = 4092;
    localparam int         LANES      = 4;

    // Signed Doppler offset of a bin relative to the centre bin.
    function automatic logic signed [5:0] bin_offset(input logic [3:0] bin, input int num_bins);
        bin_offset = $signed({2'b00, bin}) - $signed(6'(num_bins / 2));
    endfunction

endpackage

// File: rtl/prn_search_ctrl_if.sv
// Bus between the search controller and its code generator / correlator environment.
interface prn_search_ctrl_if #(
    parameter int ACC_WIDTH  = 32,
    parameter int PEAK_WIDTH = 24
);
    logic                  rx_start;
    logic                  rx_abort;
    logic [ACC_WIDTH-1:0]  rx_fcw_base;
    logic [ACC_WIDTH-1:0]  rx_fcw_step;
    logic [PEAK_WIDTH-1:0] rx_thresh;
    logic                  rx_prn_eop;
    logic                  rx_corr_valid;
    logic [PEAK_WIDTH-1:0] rx_corr_peak;
    logic                  tx_gen_rst;
    logic [ACC_WIDTH-1:0]  tx_prn_fcw;
    logic [2:0]            tx_corr_paral;
    logic [1:0]            tx_paral_index;
    logic [2:0]            tx_state;
    logic                  tx_lock;
    logic                  tx_fail;
    logic [3:0]            tx_best_bin;
    logic [9:0]            tx_best_code;

    modport master (
        output rx_start, rx_abort, rx_fcw_base, rx_fcw_step, rx_thresh,
               rx_prn_eop, rx_corr_valid, rx_corr_peak,
        input  tx_gen_rst, tx_prn_fcw, tx_corr_paral, tx_paral_index,
               tx_state, tx_lock, tx_fail, tx_best_bin, tx_best_code
    );

    modport slave (
        input  rx_start, rx_abort, rx_fcw_base, rx_fcw_step, rx_thresh,
               rx_prn_eop, rx_corr_valid, rx_corr_peak,
        output tx_gen_rst, tx_prn_fcw, tx_corr_paral, tx_paral_index,
               tx_state, tx_lock, tx_fail, tx_best_bin, tx_best_code
    );
endinterface

// File: rtl/prn_fcw_calc.sv
// Combinational Doppler-bin to NCO word: base + (bin - NUM_BINS/2) * step, modulo 2^ACC_WIDTH.
module prn_fcw_calc
    import prn_pkg::*;
#(
    parameter int ACC_WIDTH = 32,
    parameter int NUM_BINS  = 16
) (
    input  logic [ACC_WIDTH-1:0] base,
    input  logic [ACC_WIDTH-1:0] step,
    input  logic [3:0]           bin,
    output logic [ACC_WIDTH-1:0] fcw
);
    logic signed [5:0]    off_s;
    logic [ACC_WIDTH-1:0] off_ext_s;

    // Sign-extended offset makes the truncated unsigned product the correct modular result.
    always_comb begin
        off_s     = bin_offset(bin, NUM_BINS);
        off_ext_s = {{(ACC_WIDTH-6){off_s[5]}}, off_s};
        fcw       = base + off_ext_s * step;
    end
endmodule

// File: rtl/prn_search_ctrl.sv
// PRN code search controller: Doppler/code acquisition sweep then tracking hand-off.
// Optional build macro PRN_SEARCH_MAXHOLD_EN selects max-peak hold over the full sweep.
module prn_search_ctrl
    import prn_pkg::*;
#(
    parameter int ACC_WIDTH  = 32,
    parameter int NUM_BINS   = 16,
    parameter int CODE_STEPS = CODE_CHIPS / LANES,
    parameter int PEAK_WIDTH = 24
) (
    input  logic            rx_clk,
    input  logic            rx_rst_n,
    prn_search_ctrl_if.slave bus
);
    prn_state_e           state;
    logic [3:0]           bin;
    logic [9:0]           code_cnt;
    logic [3:0]           fcw_bin_s;
    logic [ACC_WIDTH-1:0] fcw_s;
    logic                 last_eop_s;
    logic                 last_bin_s;
    logic                 fail_s;
`ifdef PRN_SEARCH_MAXHOLD_EN
    logic [PEAK_WIDTH-1:0] max_peak;
`else
    logic                  hit_s;
`endif

    // Bin feeding the FCW calculator and end-of-bin / end-of-sweep decodes.
    always_comb begin
        if (state == ST_TRK_LOAD) begin
            fcw_bin_s = bus.tx_best_bin;
        end else begin
            fcw_bin_s = bin;
        end
        last_eop_s = bus.rx_prn_eop && (code_cnt == 10'(CODE_STEPS - 1));
        last_bin_s = (bin == 4'(NUM_BINS - 1));
`ifdef PRN_SEARCH_MAXHOLD_EN
        fail_s = (state == ST_BIN_STEP) && last_bin_s && (max_peak < bus.rx_thresh) && !bus.rx_abort;
`else
        hit_s  = bus.rx_corr_valid && (bus.rx_corr_peak >= bus.rx_thresh);
        fail_s = (state == ST_BIN_STEP) && last_bin_s && !bus.rx_abort;
`endif
    end

    prn_fcw_calc #(
        .ACC_WIDTH (ACC_WIDTH),
        .NUM_BINS  (NUM_BINS)
    ) u_fcw_calc (
        .base (bus.rx_fcw_base),
        .step (bus.rx_fcw_step),
        .bin  (fcw_bin_s),
        .fcw  (fcw_s)
    );

    // Search FSM; outputs are registered from the current state so they trail it by one cycle.
    always_ff @(posedge rx_clk) begin
        if (!rx_rst_n) begin
            state              <= ST_IDLE;
            bin                <= 4'd0;
            code_cnt           <= 10'd0;
            bus.tx_gen_rst     <= 1'b0;
            bus.tx_prn_fcw     <= '0;
            bus.tx_corr_paral  <= 3'b000;
            bus.tx_paral_index <= 2'd0;
            bus.tx_state       <= 3'd0;
            bus.tx_lock        <= 1'b0;
            bus.tx_fail        <= 1'b0;
            bus.tx_best_bin    <= 4'd0;
            bus.tx_best_code   <= 10'd0;
`ifdef PRN_SEARCH_MAXHOLD_EN
            max_peak           <= '0;
`endif
        end else begin
            bus.tx_state   <= state;
            bus.tx_lock    <= (state == ST_TRK);
            bus.tx_gen_rst <= (state == ST_ACQ_LOAD) || (state == ST_TRK_LOAD);
            bus.tx_fail    <= fail_s;
            if (state == ST_ACQ_LOAD) begin
                bus.tx_prn_fcw     <= fcw_s;
                bus.tx_corr_paral  <= PARAL_ACQ;
                bus.tx_paral_index <= 2'd0;
            end else if (state == ST_TRK_LOAD) begin
                bus.tx_prn_fcw     <= fcw_s;
                bus.tx_corr_paral  <= PARAL_TRK;
                bus.tx_paral_index <= 2'd0;
            end else begin
                bus.tx_prn_fcw     <= bus.tx_prn_fcw;
                bus.tx_corr_paral  <= bus.tx_corr_paral;
                bus.tx_paral_index <= bus.tx_paral_index;
            end

            if (bus.rx_abort) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (bus.rx_start) begin
                            bin      <= 4'd0;
                            code_cnt <= 10'd0;
`ifdef PRN_SEARCH_MAXHOLD_EN
                            max_peak <= '0;
`endif
                            state    <= ST_ACQ_LOAD;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                    ST_ACQ_LOAD: begin
                        code_cnt <= 10'd0;
                        state    <= ST_ACQ_RUN;
                    end
                    ST_ACQ_RUN: begin
`ifdef PRN_SEARCH_MAXHOLD_EN
                        // Strict compare keeps the earlier peak on ties.
                        if (bus.rx_corr_valid && (bus.rx_corr_peak > max_peak)) begin
                            max_peak         <= bus.rx_corr_peak;
                            bus.tx_best_bin  <= bin;
                            bus.tx_best_code <= code_cnt;
                        end else begin
                            max_peak <= max_peak;
                        end
                        if (bus.rx_prn_eop) begin
                            code_cnt <= code_cnt + 10'd1;
                            state    <= last_eop_s ? ST_BIN_STEP : ST_ACQ_RUN;
                        end else begin
                            state <= ST_ACQ_RUN;
                        end
`else
                        if (hit_s) begin
                            bus.tx_best_bin  <= bin;
                            bus.tx_best_code <= code_cnt;
                            state            <= ST_TRK_LOAD;
                        end else if (bus.rx_prn_eop) begin
                            code_cnt <= code_cnt + 10'd1;
                            state    <= last_eop_s ? ST_BIN_STEP : ST_ACQ_RUN;
                        end else begin
                            state <= ST_ACQ_RUN;
                        end
`endif
                    end
                    ST_BIN_STEP: begin
                        if (!last_bin_s) begin
                            bin   <= bin + 4'd1;
                            state <= ST_ACQ_LOAD;
                        end else begin
                            bin <= 4'd0;
`ifdef PRN_SEARCH_MAXHOLD_EN
                            state <= (max_peak >= bus.rx_thresh) ? ST_TRK_LOAD : ST_IDLE;
`else
                            state <= ST_IDLE;
`endif
                        end
                    end
                    ST_TRK_LOAD: state <= ST_TRK;
                    ST_TRK:      state <= ST_TRK;
                    default:     state <= ST_IDLE;
                endcase
            end
        end
    end
endmodule
